// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Brief    : Shared types and helpers for the branch history table predictor.
// Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam int BHT_IDX_LSB = 2;

    // Saturating step of a two-bit counter toward the observed outcome.
    function automatic bht_state_t bht_next(input bht_state_t state, input logic taken);
        bht_state_t r_nxt;
        r_nxt = state;
        case (state)
            SNT:     r_nxt = taken ? WNT : SNT;
            WNT:     r_nxt = taken ? WT  : SNT;
            WT:      r_nxt = taken ? ST  : WNT;
            ST:      r_nxt = taken ? ST  : WT;
            default: r_nxt = state;
        endcase
        return r_nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_counter.sv
`default_nettype none
// ============================================================================
// Module   : bht_counter
// Brief    : One two-bit saturating prediction counter with enable.
// Revision : 1.0 - initial release
// ============================================================================
module bht_counter
    import bp_pkg::*;
#(
    parameter logic [1:0] RESET_STATE = 2'b11
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    input  wire logic  i_en,
    input  wire logic  i_taken,
    output bht_state_t o_state
);

    bht_state_t r_state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= bht_state_t'(RESET_STATE);
        end else if (i_en) begin
            r_state <= bht_next(r_state, i_taken);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
// Module   : branch_history_table
// Brief    : PC-indexed two-bit saturating branch predictor with event counters.
//            Define BHT_BYPASS_EN to forward a same-cycle EX update to the lookup.
// Revision : 1.0 - initial release
// ============================================================================
module branch_history_table
    import bp_pkg::*;
#(
    parameter int         ENTRIES     = 16,
    parameter int         INDEX_W     = 4,
    parameter logic [1:0] RESET_STATE = 2'b11,
    parameter int         CNT_W       = 16
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              id_branch_i,
    input  wire logic [31:0]       id_pc_i,
    output logic                   predict_o,
    input  wire logic              ex_branch_i,
    input  wire logic [31:0]       ex_pc_i,
    input  wire logic              ex_taken_i,
    input  wire logic              ex_predict_i,
    output logic                   flush_o,
    output logic [CNT_W-1:0]       branch_cnt_o,
    output logic [CNT_W-1:0]       mispredict_cnt_o
);

    logic [INDEX_W-1:0] w_id_idx;
    logic [INDEX_W-1:0] w_ex_idx;
    bht_state_t         w_entry [ENTRIES];
    logic [ENTRIES-1:0] w_upd_en;
    bht_state_t         w_lookup;
    logic               w_predict_bit;
    logic               w_unused_pc;

    logic [CNT_W-1:0]   r_branch_cnt;
    logic [CNT_W-1:0]   r_mispredict_cnt;

    assign w_id_idx = id_pc_i[INDEX_W+1:BHT_IDX_LSB];
    assign w_ex_idx = ex_pc_i[INDEX_W+1:BHT_IDX_LSB];

    // Only the index bits of the PCs matter; aliasing is accepted.
    assign w_unused_pc = ^{id_pc_i[31:INDEX_W+2], id_pc_i[1:0],
                           ex_pc_i[31:INDEX_W+2], ex_pc_i[1:0]};

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        assign w_upd_en[gi] = ex_branch_i && (w_ex_idx == INDEX_W'(gi));

        bht_counter #(
            .RESET_STATE (RESET_STATE)
        ) u_counter (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .i_en    (w_upd_en[gi]),
            .i_taken (ex_taken_i),
            .o_state (w_entry[gi])
        );
    end

    assign w_lookup = w_entry[w_id_idx];

`ifdef BHT_BYPASS_EN
    bht_state_t w_ex_next;
    assign w_ex_next     = bht_next(w_entry[w_ex_idx], ex_taken_i);
    assign w_predict_bit = (ex_branch_i && (w_id_idx == w_ex_idx)) ? w_ex_next[1]
                                                                   : w_lookup[1];
`else
    assign w_predict_bit = w_lookup[1];
`endif

    assign predict_o = id_branch_i & w_predict_bit;
    assign flush_o   = ex_branch_i & (ex_taken_i != ex_predict_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (ex_branch_i) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (flush_o && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
        end
    end

    assign branch_cnt_o     = r_branch_cnt;
    assign mispredict_cnt_o = r_mispredict_cnt;

endmodule
`default_nettype wire
